// File: rtl/rope_flash_sequencer_if.sv
// Bus bundle between rope_flash_sequencer and its environment.
// Groups the AGC strobe/address, monitor handshake, flash pins and sense bus.
//   slave  : sequencer view (takes requests, drives flash and sense bus)
//   master : environment view (AGC logic, monitor, flash model, sense amps)
interface rope_flash_sequencer_if #(
    parameter int ADDR_W = 17
);
    logic              SBF;
    logic [ADDR_W-1:0] FADDR;
    logic              MON_REQ;
    logic [ADDR_W-1:0] MON_ADDR;
    logic              MON_ACK;
    logic [15:0]       MON_DATA;
    logic [ADDR_W-1:0] FL_ADDR;
    logic              FL_CE_n;
    logic              FL_OE_n;
    logic [15:0]       FL_DQ;
    logic [15:0]       SA_OUT;
    logic              BUSY;
    logic              PAR_ERR;

    modport slave (
        input  SBF, FADDR, MON_REQ, MON_ADDR, FL_DQ,
        output MON_ACK, MON_DATA, FL_ADDR, FL_CE_n, FL_OE_n,
        output SA_OUT, BUSY, PAR_ERR
    );

    modport master (
        output SBF, FADDR, MON_REQ, MON_ADDR, FL_DQ,
        input  MON_ACK, MON_DATA, FL_ADDR, FL_CE_n, FL_OE_n,
        input  SA_OUT, BUSY, PAR_ERR
    );
endinterface

// File: rtl/rope_flash_sequencer.sv
// Rope/erasable flash read sequencer shared by the AGC sense strobe (SBF)
// and a monitor read port; AGC requests always win, no preemption.
// Ports: SIM_CLK (rising-edge clock), SIM_RST (async, active-high),
//   bus (slave): SBF/FADDR AGC request, MON_REQ/MON_ADDR/MON_ACK/MON_DATA
//   monitor handshake, FL_ADDR/FL_CE_n/FL_OE_n/FL_DQ flash pins,
//   SA_OUT sense bus drive, BUSY, PAR_ERR.
// Option: define ROPE_PARITY_CHECK_EN to build the sticky odd-parity checker.
module rope_flash_sequencer #(
    parameter int ACCESS_CYCLES = 4,
    parameter int ADDR_W        = 17
) (
    input  logic                  SIM_CLK,
    input  logic                  SIM_RST,
    rope_flash_sequencer_if.slave bus
);
    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_CAPTURE,
        S_HOLD
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_take_agc;
    logic              w_take_mon;
    logic              w_sbf_rise;
    logic              r_sbf_q;
    logic              r_pending;
    logic              r_src_agc;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_faddr;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_fl_addr;
    logic              r_ce_n;
    logic              r_oe_n;
    logic [15:0]       r_sa;
    logic              r_mon_ack;
    logic [15:0]       r_mon_data;

    assign w_sbf_rise = bus.SBF & ~r_sbf_q;

    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // The ack cycle blocks a new monitor grant so a requester that drops
    // MON_REQ on seeing MON_ACK is never served twice.
    always_comb begin
        w_next     = r_state;
        w_take_agc = 1'b0;
        w_take_mon = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_pending) begin
                    w_next     = S_SETUP;
                    w_take_agc = 1'b1;
                end else if (bus.MON_REQ && !r_mon_ack) begin
                    w_next     = S_SETUP;
                    w_take_mon = 1'b1;
                end
            end
            S_SETUP: w_next = S_WAIT;
            S_WAIT: begin
                if (r_cnt == 4'd0) w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (r_src_agc && bus.SBF) w_next = S_HOLD;
                else                      w_next = S_IDLE;
            end
            S_HOLD: begin
                if (!bus.SBF) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // r_faddr keeps collecting the latest SBF rise while r_addr holds the
    // address of the read actually in progress.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            r_sbf_q    <= 1'b0;
            r_pending  <= 1'b0;
            r_src_agc  <= 1'b0;
            r_cnt      <= 4'd0;
            r_faddr    <= '0;
            r_addr     <= '0;
            r_fl_addr  <= '0;
            r_ce_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_sa       <= 16'd0;
            r_mon_ack  <= 1'b0;
            r_mon_data <= 16'd0;
        end else begin
            r_sbf_q   <= bus.SBF;
            r_mon_ack <= 1'b0;
            if (w_sbf_rise) begin
                r_faddr   <= bus.FADDR;
                r_pending <= 1'b1;
            end else if (w_take_agc) begin
                r_pending <= 1'b0;
            end
            if (w_take_agc) begin
                r_addr    <= r_faddr;
                r_src_agc <= 1'b1;
            end
            if (w_take_mon) begin
                r_addr    <= bus.MON_ADDR;
                r_src_agc <= 1'b0;
            end
            case (r_state)
                S_SETUP: begin
                    r_fl_addr <= r_addr;
                    r_ce_n    <= 1'b0;
                    r_oe_n    <= 1'b0;
                    r_cnt     <= CNT_INIT;
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                end
                S_CAPTURE: begin
                    r_ce_n <= 1'b1;
                    r_oe_n <= 1'b1;
                    if (r_src_agc) begin
                        if (bus.SBF) r_sa <= bus.FL_DQ;
                    end else begin
                        r_mon_data <= bus.FL_DQ;
                        r_mon_ack  <= bus.MON_REQ;
                    end
                end
                S_HOLD: begin
                    if (!bus.SBF) r_sa <= 16'd0;
                end
                default: ;
            endcase
        end
    end

`ifdef ROPE_PARITY_CHECK_EN
    logic r_par_err;

    // Good rope words carry odd parity over all 16 bits.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            r_par_err <= 1'b0;
        end else if (r_state == S_CAPTURE && !(^bus.FL_DQ)) begin
            r_par_err <= 1'b1;
        end
    end

    assign bus.PAR_ERR = r_par_err;
`else
    assign bus.PAR_ERR = 1'b0;
`endif

    assign bus.FL_ADDR  = r_fl_addr;
    assign bus.FL_CE_n  = r_ce_n;
    assign bus.FL_OE_n  = r_oe_n;
    assign bus.SA_OUT   = r_sa;
    assign bus.MON_ACK  = r_mon_ack;
    assign bus.MON_DATA = r_mon_data;
    assign bus.BUSY     = (r_state != S_IDLE);
endmodule

// File: tb/tb_rope_flash_sequencer.sv
// Directed bench for rope_flash_sequencer: table of single reads plus
// hand sequences for arbitration, short strobes, dropped requests and reset.
module tb_rope_flash_sequencer;
    logic clk = 1'b0;
    logic SIM_RST;
    int   total = 0;
    int   bad   = 0;
    logic exp_par = 1'b0;

    always #5 clk = ~clk;

    rope_flash_sequencer_if #(.ADDR_W(17)) bus ();

    rope_flash_sequencer #(
        .ACCESS_CYCLES(4),
        .ADDR_W(17)
    ) dut (
        .SIM_CLK(clk),
        .SIM_RST(SIM_RST),
        .bus(bus)
    );

    typedef struct {
        bit          mon;
        logic [16:0] addr;
        logic [15:0] dq;
        int          hold;
        logic [15:0] exp_data;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_read(input logic [15:0] dq);
`ifdef ROPE_PARITY_CHECK_EN
        exp_par = exp_par | ~(^dq);
`endif
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_busy"}, 32'(bus.BUSY), 0);
        chk({tag, "_sa_off"}, 32'(bus.SA_OUT), 0);
        chk({tag, "_ce_n"}, 32'(bus.FL_CE_n), 1);
        chk({tag, "_oe_n"}, 32'(bus.FL_OE_n), 1);
        chk({tag, "_par"}, 32'(bus.PAR_ERR), 32'(exp_par));
    endtask

    task automatic agc_read(input logic [16:0] a, input logic [15:0] dq,
                            input int hold, input logic [15:0] exp_sa);
        int n;
        bit nz;
        nz = 0;
        n = (hold < 8 ? 8 : hold) + 2;
        bus.FADDR = a;
        bus.FL_DQ = dq;
        bus.SBF   = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == 3) begin
                chk("agc_fl_addr", 32'(bus.FL_ADDR), 32'(a));
                chk("agc_ce_n_low", 32'(bus.FL_CE_n), 0);
            end
            if (i == 7) chk("agc_sa_early", 32'(bus.SA_OUT), 0);
            if (i == 8) chk("agc_sa", 32'(bus.SA_OUT), 32'(exp_sa));
            if (bus.SA_OUT != 16'd0 && exp_sa == 16'd0) nz = 1;
            if (i == hold) bus.SBF = 1'b0;
        end
        note_read(dq);
        if (exp_sa == 16'd0) chk("agc_sa_never", 32'(nz), 0);
        idle_checks("agc_end");
    endtask

    task automatic mon_read(input logic [16:0] a, input logic [15:0] dq,
                            input logic [15:0] exp_d);
        int acks;
        bit nz;
        acks = 0;
        nz = 0;
        bus.MON_ADDR = a;
        bus.FL_DQ    = dq;
        bus.MON_REQ  = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 3) chk("mon_fl_addr", 32'(bus.FL_ADDR), 32'(a));
            if (bus.MON_ACK) begin
                acks++;
                chk("mon_data", 32'(bus.MON_DATA), 32'(exp_d));
                chk("mon_ack_cycle", 32'(i), 7);
                bus.MON_REQ = 1'b0;
            end
            if (bus.SA_OUT != 16'd0) nz = 1;
        end
        note_read(dq);
        chk("mon_ack_count", 32'(acks), 1);
        chk("mon_sa_quiet", 32'(nz), 0);
        idle_checks("mon_end");
    endtask

    initial begin
        int ack_i;
        int sa_i;
        int acks;

        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int ack_i;
        int sa_i;
        int acks;

        tbl[0] = '{0, 17'h02345, 16'hA5C3, 12, 16'hA5C3};
        tbl[1] = '{1, 17'h1FFFF, 16'h1234, 0, 16'h1234};
        tbl[2] = '{0, 17'h00000, 16'hFFFF, 10, 16'hFFFF};
        tbl[3] = '{0, 17'h1FFFF, 16'h8001, 3, 16'h0000};
        tbl[4] = '{1, 17'h00000, 16'h0000, 0, 16'h0000};
        tbl[5] = '{0, 17'h10000, 16'h7FFE, 8, 16'h7FFE};
        tbl[6] = '{0, 17'h0C0DE, 16'h4321, 7, 16'h0000};

        SIM_RST      = 1'b1;
        bus.SBF      = 1'b0;
        bus.FADDR    = '0;
        bus.MON_REQ  = 1'b0;
        bus.MON_ADDR = '0;
        bus.FL_DQ    = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_mon_ack", 32'(bus.MON_ACK), 0);
        chk("rst_mon_data", 32'(bus.MON_DATA), 0);
        chk("rst_fl_addr", 32'(bus.FL_ADDR), 0);
        idle_checks("rst");
        SIM_RST = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            if (tbl[v].mon) mon_read(tbl[v].addr, tbl[v].dq, tbl[v].exp_data);
            else agc_read(tbl[v].addr, tbl[v].dq, tbl[v].hold, tbl[v].exp_data);
        end

        // AGC rises twice during a monitor read: monitor finishes first,
        // then the AGC read uses the address of the last rise.
        ack_i = 0;
        sa_i  = 0;
        bus.MON_ADDR = 17'h0ABCD;
        bus.FL_DQ    = 16'h5555;
        bus.MON_REQ  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.FADDR = 17'h0AAAA;
        bus.SBF   = 1'b1;
        @(negedge clk);
        bus.SBF   = 1'b0;
        @(negedge clk);
        bus.FADDR = 17'h0F0F0;
        bus.SBF   = 1'b1;
        for (int i = 5; i <= 40 && sa_i == 0; i++) begin
            @(negedge clk);
            if (bus.MON_ACK) begin
                ack_i = i;
                chk("arb_mon_data", 32'(bus.MON_DATA), 32'h5555);
                bus.MON_REQ = 1'b0;
                bus.FL_DQ   = 16'h3C3C;
            end
            if (bus.SA_OUT != 16'd0) begin
                sa_i = i;
                chk("arb_sa", 32'(bus.SA_OUT), 32'h3C3C);
                chk("arb_last_addr", 32'(bus.FL_ADDR), 32'h0F0F0);
            end
        end
        chk("arb_sa_seen", 32'(sa_i != 0), 1);
        chk("arb_ack_first", 32'(ack_i != 0 && ack_i < sa_i), 1);
        chk("arb_latency_ok", 32'((sa_i - 5) <= 14), 1);
        note_read(16'h5555);
        note_read(16'h3C3C);
        bus.SBF = 1'b0;
        repeat (2) @(negedge clk);
        idle_checks("arb_end");

        // Monitor request withdrawn mid-read: read runs, no ack.
        acks = 0;
        bus.MON_ADDR = 17'h01234;
        bus.FL_DQ    = 16'h0101;
        bus.MON_REQ  = 1'b1;
        repeat (3) @(negedge clk);
        bus.MON_REQ = 1'b0;
        chk("drop_busy_mid", 32'(bus.BUSY), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.MON_ACK) acks++;
        end
        note_read(16'h0101);
        chk("drop_no_ack", 32'(acks), 0);
        chk("drop_mon_data", 32'(bus.MON_DATA), 32'h0101);
        idle_checks("drop_end");

        // Reset while the flash is being accessed.
        bus.FADDR = 17'h00777;
        bus.FL_DQ = 16'hBEEF;
        bus.SBF   = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_mid_ce_low", 32'(bus.FL_CE_n), 0);
        #2 SIM_RST = 1'b1;
        exp_par = 1'b0;
        #1;
        idle_checks("rst_mid");
        bus.SBF = 1'b0;
        @(negedge clk);
        @(negedge clk);
        SIM_RST = 1'b0;
        @(negedge clk);
        agc_read(17'h00777, 16'h0001, 10, 16'h0001);
        agc_read(17'h00778, 16'h0003, 10, 16'h0003);
        agc_read(17'h00779, 16'h0001, 10, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
